// File: rtl/i2c_regbank.sv
// Application-side register bank for the I2C slave: GP registers, control,
// sticky status, a 16-bit event counter with atomic hi-byte snapshot, and an ID byte.
module i2c_regbank #(
  parameter int         NREG     = 8,
  parameter logic [7:0] GP_RESET = 8'h00,
  parameter logic [7:0] ID_VALUE = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rw,
  input  logic [7:0]        addr,
  input  logic              wen,
  input  logic [7:0]        wdata,
  input  logic              rdata_used,
  output logic [7:0]        rdata,
  input  logic              event_i,
  output logic              irq_o,
  output logic [8*NREG-1:0] gp_o
);

  localparam logic [7:0] A_CTRL   = 8'h08;
  localparam logic [7:0] A_STATUS = 8'h09;
  localparam logic [7:0] A_CNT_LO = 8'h0A;
  localparam logic [7:0] A_CNT_HI = 8'h0B;
  localparam logic [7:0] A_ID     = 8'h0F;
  localparam logic [7:0] NREG_B   = 8'(NREG);
  localparam int         IW       = (NREG > 1) ? $clog2(NREG) : 1;

  logic [7:0]    gp_q [NREG];
  logic          cnt_en_q, irq_en_q;
  logic          ovf_q, evt_q;
  logic [15:0]   cnt_q;
  logic [7:0]    shadow_q;

  logic          is_gp;
  logic [IW-1:0] gidx;
  logic          cnt_clr, sts_clr, ovf_set;
  logic [15:0]   cnt_d;
  logic          ovf_d, evt_d;
  logic [7:0]    rd_d;

  // The direction bit is informational; the address alone selects the register.
  logic unused_rw;
  assign unused_rw = rw;

  assign is_gp = (addr < NREG_B);
  assign gidx  = addr[IW-1:0];

  for (genvar i = 0; i < NREG; i++) begin : g_gp_out
    assign gp_o[8*i +: 8] = gp_q[i];
  end

  // Counter and sticky-status next state. Clear beats increment; a set beats
  // clear-on-read. cnt_en is the registered value, so a same-cycle CTRL write
  // cannot mask the event being counted.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path can leave a value held (which would infer a latch).
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    cnt_clr = wen && (addr == A_CTRL) && wdata[2];
    sts_clr = rdata_used && (addr == A_STATUS);
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (event_i && cnt_en_q) begin
      cnt_d   = cnt_q + 16'd1;
      ovf_set = (cnt_q == 16'hFFFF);
    end
    ovf_d = (ovf_q & ~sts_clr) | ovf_set;
    evt_d = (evt_q & ~sts_clr) | event_i;
  end

  always_comb begin
    rd_d = 8'h00;
    if (is_gp) begin
      rd_d = gp_q[gidx];
    end else begin
      case (addr)
        A_CTRL:   rd_d = {6'b0, irq_en_q, cnt_en_q};
        A_STATUS: rd_d = {6'b0, evt_q, ovf_q};
        A_CNT_LO: rd_d = cnt_q[7:0];
        A_CNT_HI: rd_d = shadow_q;
        A_ID:     rd_d = ID_VALUE;
        default:  rd_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the GP array is software-visible state with a defined reset value,
      // so every entry is reset (it is flops, not a RAM macro).
      for (int i = 0; i < NREG; i++) gp_q[i] <= GP_RESET;
      cnt_en_q <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      evt_q    <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= 8'h00;
      rdata    <= 8'h00;
      irq_o    <= 1'b0;
    end else begin
      if (wen && is_gp) gp_q[gidx] <= wdata;
      if (wen && (addr == A_CTRL)) begin
        cnt_en_q <= wdata[0];
        irq_en_q <= wdata[1];
      end
      // Snapshot uses the pre-increment counter so LO/HI form one coherent value.
      if (rdata_used && (addr == A_CNT_LO)) shadow_q <= cnt_q[15:8];
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      evt_q <= evt_d;
      rdata <= rd_d;
      irq_o <= irq_en_q & ovf_q;
    end
  end

endmodule

// File: doc/i2c_regbank.md
Name: i2c_regbank

Overview:
- Register bank on the application side of the I2C slave.
- Consumes the slave's rw/addr/wen/wdata/rdata_used bus and returns an 8-bit rdata byte for the slave to shift out.
- Holds general-purpose RW registers, a control register, a sticky status register, a 16-bit event counter with atomic snapshot read, and an ID byte.
- Drives an interrupt line and exposes the GP registers to the core logic.

Parameters:
- NREG, 8, number of general-purpose RW registers at addresses 0x00..NREG-1. Legal range 1..8.
- GP_RESET, 8'h00, reset value of every GP register.
- ID_VALUE, 8'hA5, constant returned at address 0x0F.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rw  in  1  transaction direction from the slave (1 = read); informational only
- addr  in  8  register address from the slave
- wen  in  1  one-cycle write strobe; write wdata to addr
- wdata  in  8  write data, valid while wen=1
- rdata_used  in  1  one-cycle pulse; the byte at addr has been captured by the slave
- rdata  out  8  registered read data for the current addr
- event_i  in  1  single-cycle event pulse from the core
- irq_o  out  1  interrupt request, registered
- gp_o  out  8*NREG  concatenated GP registers; reg 0 in bits [7:0]

Behaviour:
- Clock and reset: all state on posedge clk; rst_n low clears asynchronously.
- Reset values:
  - GP regs = GP_RESET
  - CTRL = 0x00, STATUS = 0x00, counter = 0, shadow = 0
  - rdata = 0x00, irq_o = 0
- Address map:
  - 0x00..NREG-1: GP, RW.
  - 0x08 CTRL, RW:
    - bit0 cnt_en
    - bit1 irq_en
    - bit2 cnt_clr: write-1 self-clearing, always reads 0
    - bits7:3 read 0, writes ignored
  - 0x09 STATUS, RO, clear-on-read:
    - bit0 ovf_pend
    - bit1 evt_seen
    - bits7:2 read 0
  - 0x0A CNT_LO, RO: counter[7:0]. A read also copies counter[15:8] into shadow.
  - 0x0B CNT_HI, RO: returns shadow.
  - 0x0F ID, RO: ID_VALUE.
  - All other addresses read 0x00; writes are ignored.
  - Writes to RO addresses are ignored.
- Read path:
  - rdata is re-registered every cycle from the current addr.
  - Latency: 1 clk after addr changes. The slave samples many clks later.
- Side effects on rdata_used=1:
  - Taken against the addr present in the same cycle (the slave updates addr in that cycle, so the pre-increment value is the one read).
  - addr=0x09: clear STATUS bits [1:0].
  - addr=0x0A: shadow <= counter[15:8], using the pre-increment counter value of that cycle.
  - No side effects for other addresses.
- Write path: on wen=1, the target register updates on that clk edge. Readback is visible on rdata 2 clks after wen.
- Counter:
  - 16-bit.
  - On event_i=1 with cnt_en=1: counter+1, wrapping 0xFFFF -> 0x0000.
  - Wrap sets ovf_pend.
  - Any event_i=1 sets evt_seen, regardless of cnt_en.
- Simultaneous events:
  - cnt_clr write and event_i in the same cycle: counter = 0 (clear wins); evt_seen still sets.
  - STATUS clear-on-read and a set condition in the same cycle: set wins (bit reads 1 afterwards).
  - CTRL write clearing cnt_en and event_i in the same cycle: event counted with the old cnt_en.
- Interrupt: irq_o <= irq_en & ovf_pend, registered, 1-clk lag.
- Reset mid-transaction: everything returns to reset values immediately. The slave's own FSM resync is its responsibility.

Test Plan:
- Reset defaults: rst_n low then high -> rdata=0x00, irq_o=0, gp_o all GP_RESET; addr=0x0F -> rdata=0xA5 2 clks later.
- GP write/readback: wen with addr=0x03, wdata=0x5C -> gp_o[31:24]=0x5C next clk; addr=0x03 -> rdata=0x5C; write to 0x09 -> STATUS unchanged.
- Counter snapshot:
  - Set cnt_en, issue 0x0123 event pulses.
  - Read 0x0A with rdata_used -> 0x23.
  - 5 more events, then read 0x0B -> 0x01.
  - Live counter is 0x0128.
- Overflow/irq:
  - CTRL=0x03, preload by 0xFFFF events, 1 more event -> counter=0, ovf_pend=1, irq_o=1 one clk later.
  - rdata_used at 0x09 -> irq_o=0 two clks later.
- Collisions:
  - cnt_clr write coincident with event_i -> counter=0, evt_seen=1.
  - STATUS rdata_used coincident with a wrap -> ovf_pend stays 1.
- Async reset mid-operation: assert rst_n low between clk edges with counter nonzero -> all outputs reset before the next edge.
